// File: rtl/nn_layer_pkg.sv
// nn_layer_pkg: shared widths, latencies and state encodings
// for the fully-connected layer datapath (framer + nodes).
package nn_layer_pkg;

    localparam int ACT_W        = 8;
    localparam int NODE_LATENCY = 3;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } framer_state_t;

endpackage

// File: rtl/act_window_buf.sv
// act_window_buf: N_IN x ACT_W lane register with write-at-index,
// zero-pad above the written lane, shift-down-by-STRIDE and clear.
// Ports: clk, reset (async active-low), wr_en/wr_idx/wr_data write
// one lane, pad_en zeroes lanes above wr_idx on that write,
// shift_en moves lane i+STRIDE into lane i, clr_en zeroes all lanes,
// act_bus is the flat lane view (lane 0 in the low byte).
module act_window_buf
    import nn_layer_pkg::*;
#(
    parameter int N_IN   = 30,
    parameter int STRIDE = 30,
    parameter int IDX_W  = $clog2(N_IN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [ACT_W-1:0]      wr_data,
    input  logic                  pad_en,
    input  logic                  shift_en,
    input  logic                  clr_en,
    output logic [ACT_W*N_IN-1:0] act_bus
);

    for (genvar i = 0; i < N_IN; i++) begin : g_lane
        logic [ACT_W-1:0] lane_q;
        logic [ACT_W-1:0] shift_src;

        // Lanes with no source above them refill with zero on a shift.
        if (i + STRIDE < N_IN) begin : g_src
            assign shift_src = act_bus[ACT_W*(i+STRIDE) +: ACT_W];
        end else begin : g_zero
            assign shift_src = '0;
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lane_q <= '0;
            end else if (clr_en) begin
                lane_q <= '0;
            end else if (shift_en) begin
                lane_q <= shift_src;
            end else if (wr_en && (wr_idx == IDX_W'(i))) begin
                lane_q <= wr_data;
            end else if (wr_en && pad_en && (wr_idx < IDX_W'(i))) begin
                lane_q <= '0;
            end
        end

        assign act_bus[ACT_W*i +: ACT_W] = lane_q;
    end

endmodule

// File: rtl/layer_input_framer.sv
// layer_input_framer: collects N_IN streamed activations into a
// parallel bus, holds it HOLD_CYCLES for the node pipeline, strobes.
// Ports: clk, reset (async active-low), s_data/s_valid/s_last/s_ready
// input stream, act_bus parallel frame, frame_valid during hold,
// frame_padded when s_last closed a short frame, result_strobe when
// node outputs are valid, frame_cnt frames issued since reset.
module layer_input_framer
    import nn_layer_pkg::*;
#(
    parameter int N_IN        = 30,
    parameter int STRIDE      = 30,
    parameter int HOLD_CYCLES = NODE_LATENCY,
    parameter int CNT_W       = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ACT_W-1:0]      s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic [ACT_W*N_IN-1:0] act_bus,
    output logic                  frame_valid,
    output logic                  frame_padded,
    output logic                  result_strobe,
    output logic [CNT_W-1:0]      frame_cnt
);

    localparam int IDX_W = $clog2(N_IN + 1);
    localparam int HLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    if (STRIDE < 1 || STRIDE > N_IN) begin : g_bad_stride
        $error("layer_input_framer: STRIDE must lie in 1..N_IN");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
        $error("layer_input_framer: HOLD_CYCLES must be at least 1");
    end

    framer_state_t    state_q, state_d;
    logic [IDX_W-1:0] fill_q, fill_d, fill_inc;
    logic [HLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fv_q, fv_d;
    logic             pad_q, pad_d;
    logic             strobe_q, strobe_d;
    logic             rdy_q, rdy_d;
    logic             last_q, last_d;
    logic             accept, full, frame_done, hold_done;
    logic             shift_en, clr_en;

    assign accept     = s_valid && rdy_q;
    assign fill_inc   = fill_q + 1'b1;
    assign full       = (fill_inc == IDX_W'(N_IN));
    assign frame_done = accept && (full || s_last);
    assign hold_done  = (state_q == ST_HOLD) &&
                        (hold_q == HLD_W'(HOLD_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        hold_d   = hold_q;
        cnt_d    = cnt_q;
        fv_d     = fv_q;
        pad_d    = pad_q;
        strobe_d = 1'b0;
        rdy_d    = rdy_q;
        last_d   = last_q;
        shift_en = 1'b0;
        clr_en   = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                rdy_d = 1'b1;
                if (accept) begin
                    fill_d = fill_inc;
                    if (frame_done) begin
                        state_d = ST_HOLD;
                        hold_d  = '0;
                        fv_d    = 1'b1;
                        pad_d   = s_last && !full;
                        rdy_d   = 1'b0;
                        last_d  = s_last;
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                hold_d = hold_q + 1'b1;
                if (hold_done) begin
                    state_d  = ST_FILL;
                    hold_d   = '0;
                    fv_d     = 1'b0;
                    pad_d    = 1'b0;
                    strobe_d = 1'b1;
                    rdy_d    = 1'b1;
                    last_d   = 1'b0;
                    fill_d   = '0;
                    // A record boundary never carries overlap into the next frame.
                    if (last_q) begin
                        clr_en = 1'b1;
                    end else if (STRIDE < N_IN) begin
                        shift_en = 1'b1;
                        fill_d   = IDX_W'(N_IN - STRIDE);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_FILL;
            fill_q   <= '0;
            hold_q   <= '0;
            cnt_q    <= '0;
            fv_q     <= 1'b0;
            pad_q    <= 1'b0;
            strobe_q <= 1'b0;
            rdy_q    <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            fill_q   <= fill_d;
            hold_q   <= hold_d;
            cnt_q    <= cnt_d;
            fv_q     <= fv_d;
            pad_q    <= pad_d;
            strobe_q <= strobe_d;
            rdy_q    <= rdy_d;
            last_q   <= last_d;
        end
    end

    act_window_buf #(
        .N_IN   (N_IN),
        .STRIDE (STRIDE),
        .IDX_W  (IDX_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (accept),
        .wr_idx   (fill_q),
        .wr_data  (s_data),
        .pad_en   (s_last),
        .shift_en (shift_en),
        .clr_en   (clr_en),
        .act_bus  (act_bus)
    );

    assign s_ready       = rdy_q;
    assign frame_valid   = fv_q;
    assign frame_padded  = pad_q;
    assign result_strobe = strobe_q;
    assign frame_cnt     = cnt_q;

endmodule
